// File: rtl/mem_responder_if.sv
// Memory-side burst interface between an accelerator (master) and a memory responder (slave).
// Request channel: one-cycle strobe with opcode/len/addr. Write channel: mem_wr_valid/mem_wr_bits beats.
// Read channel: mem_rd_valid/mem_rd_bits beats, flow-controlled by mem_rd_ready.
interface mem_responder_if #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
);
    logic                     mem_req_valid;
    logic                     mem_req_opcode;   // 0 = read, 1 = write
    logic [MEM_LEN_BITS-1:0]  mem_req_len;      // beats - 1
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;     // byte address of first beat
    logic                     mem_wr_valid;
    logic [MEM_DATA_BITS-1:0] mem_wr_bits;
    logic                     mem_rd_valid;
    logic [MEM_DATA_BITS-1:0] mem_rd_bits;
    logic                     mem_rd_ready;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_rd_ready,
        input  mem_rd_valid, mem_rd_bits
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
        output mem_rd_valid, mem_rd_bits
    );
endinterface

// File: rtl/mem_responder.sv
// Purpose: serves accelerator burst reads/writes from an internal word-addressed RAM.
// Latency: write beats absorbed the cycle they arrive; first read beat two cycles after the request.
// Backpressure: reads stall on mem_rd_ready via a 2-entry skid buffer; requests while busy are dropped and set err.
// Ports: clock/reset (sync, active-high), mem (slave side of mem_responder_if),
//        busy (state not IDLE), err (sticky overlap-request flag).
module mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_BITS    = 10
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  mem,
    output logic            busy,
    output logic            err
);
    localparam int CNT_W = MEM_LEN_BITS + 1;
    localparam int WORDS = 1 << DEPTH_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t state, state_nxt;

    logic [DEPTH_BITS-1:0]    idx;          // word address of the next beat to write / issue
    logic [CNT_W-1:0]         beats_left;   // write: beats still to accept; read: RAM reads still to issue
    logic [CNT_W-1:0]         cmp_left;     // read beats still to hand over
    logic [MEM_DATA_BITS-1:0] ram [WORDS];
    logic [MEM_DATA_BITS-1:0] ram_q;
    logic                     rd_pend;      // ram_q holds a beat issued last cycle
    logic [MEM_DATA_BITS-1:0] skid [2];
    logic [1:0]               skid_cnt;

    logic       req_accept, wr_beat, rd_issue, rd_pop, pop_buf, push, push_pos;
    logic [2:0] occ;

    // Address offset bits and upper alias bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_req_addr[2:0], mem.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS+3]};

    assign busy   = (state != ST_IDLE);
    assign rd_pop = mem.mem_rd_valid && mem.mem_rd_ready;

    // Oldest beat is the skid head; with an empty skid the RAM output is forwarded directly,
    // which is what gives the two-cycle first-beat latency.
    assign mem.mem_rd_valid = (skid_cnt != 2'd0) || rd_pend;
    assign mem.mem_rd_bits  = (skid_cnt != 2'd0) ? skid[0] :
                              (rd_pend ? ram_q : '0);

    // Beats held after this cycle's handover (skid + in-flight RAM read).
    assign occ = {1'b0, skid_cnt} + {2'b0, rd_pend} - {2'b0, rd_pop};

    always_comb begin
        state_nxt  = state;
        req_accept = 1'b0;
        wr_beat    = 1'b0;
        rd_issue   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_accept = mem.mem_req_valid;
                if (mem.mem_req_valid)
                    state_nxt = mem.mem_req_opcode ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                wr_beat = mem.mem_wr_valid;
                if (mem.mem_wr_valid && beats_left == CNT_W'(1))
                    state_nxt = ST_IDLE;
            end
            ST_READ: begin
                // Issue only if the beat will have a slot when it lands next cycle.
                rd_issue = (beats_left != '0) && (occ < 3'd2);
                if (rd_pop && cmp_left == CNT_W'(1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A RAM beat goes into the skid unless it is handed straight over from an empty skid.
    assign pop_buf  = rd_pop && (skid_cnt != 2'd0);
    assign push     = rd_pend && !(rd_pop && skid_cnt == 2'd0);
    assign push_pos = (skid_cnt == 2'd2) || (skid_cnt == 2'd1 && !pop_buf);

    always_ff @(posedge clock) begin
        if (reset) begin
            idx        <= '0;
            beats_left <= '0;
            cmp_left   <= '0;
            rd_pend    <= 1'b0;
            skid_cnt   <= 2'd0;
            err        <= 1'b0;
        end else begin
            if (mem.mem_req_valid && state != ST_IDLE)
                err <= 1'b1;
            if (req_accept) begin
                idx        <= mem.mem_req_addr[DEPTH_BITS+2:3];
                beats_left <= {1'b0, mem.mem_req_len} + CNT_W'(1);
                cmp_left   <= {1'b0, mem.mem_req_len} + CNT_W'(1);
            end else if (wr_beat || rd_issue) begin
                idx        <= idx + DEPTH_BITS'(1);
                beats_left <= beats_left - CNT_W'(1);
            end
            if (rd_pop)
                cmp_left <= cmp_left - CNT_W'(1);
            rd_pend  <= rd_issue;
            skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop_buf};
        end
    end

    // Storage without reset: RAM contents survive reset, skid data is qualified by skid_cnt.
    always_ff @(posedge clock) begin
        if (wr_beat && !reset)
            ram[idx] <= mem.mem_wr_bits;
        if (rd_issue)
            ram_q <= ram[idx];
        if (pop_buf)
            skid[0] <= skid[1];
        if (push)
            skid[push_pos] <= ram_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized bursts against a word-array memory model.
module tb_mem_responder;
    localparam int DEPTH = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy, err;

    mem_responder_if #(.MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64)) mif ();

    mem_responder #(.MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64), .DEPTH_BITS(10)) dut (
        .clock (clock),
        .reset (reset),
        .mem   (mif.slave),
        .busy  (busy),
        .err   (err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [63:0] model [DEPTH];
    bit          known [DEPTH];
    logic [63:0] wdata [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int word_of(input logic [63:0] addr);
        return int'((addr >> 3) % 64'(DEPTH));
    endfunction

    task automatic pulse_reset;
        reset = 1'b1;
        mif.mem_req_valid = 1'b0;
        mif.mem_wr_valid  = 1'b0;
        mif.mem_rd_ready  = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // stall_mode: 0 none, 1 random 0..2 idle cycles before each beat, 2 three idle cycles before the first beat
    task automatic do_write(input logic [63:0] addr, input int len, input int stall_mode);
        int base;
        int stalls;
        base = word_of(addr);
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_opcode = 1'b1;
        mif.mem_req_len    = 8'(len);
        mif.mem_req_addr   = addr;
        mif.mem_wr_valid   = 1'b1;            // data alongside the request must be ignored
        mif.mem_wr_bits    = 64'hDEAD_DEAD_DEAD_DEAD;
        tick;
        mif.mem_req_valid = 1'b0;
        mif.mem_wr_valid  = 1'b0;
        check("wr_busy_rise", 64'(busy), 64'd1);
        for (int i = 0; i <= len; i++) begin
            stalls = (stall_mode == 1) ? int'($urandom_range(0, 2)) :
                     (stall_mode == 2 && i == 0) ? 3 : 0;
            for (int s = 0; s < stalls; s++) begin
                mif.mem_wr_bits = {$urandom, $urandom};
                tick;
                check("wr_busy_stall", 64'(busy), 64'd1);
            end
            mif.mem_wr_valid = 1'b1;
            mif.mem_wr_bits  = wdata[i];
            tick;
            model[(base + i) % DEPTH] = wdata[i];
            known[(base + i) % DEPTH] = 1'b1;
            mif.mem_wr_valid = 1'b0;
            if (i < len)
                check("wr_busy_mid", 64'(busy), 64'd1);
        end
        check("wr_busy_fall", 64'(busy), 64'd0);
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready
    // inject: raise an overlapping request (with a stray write beat) during the burst
    // abort_left: if nonzero, reset once that many beats remain
    task automatic do_read(input logic [63:0] addr, input int len, input int mode,
                           input bit lat_chk, input bit inject, input int abort_left);
        int base, done, cyc, first, last;
        bit stalled, rdy;
        logic [63:0] prev_bits;
        base = word_of(addr);
        done = 0; first = -1; last = -1; stalled = 1'b0; prev_bits = '0;
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_opcode = 1'b0;
        mif.mem_req_len    = 8'(len);
        mif.mem_req_addr   = addr;
        tick;
        mif.mem_req_valid = 1'b0;
        cyc = 1;
        check("rd_busy_rise", 64'(busy), 64'd1);
        if (lat_chk)
            check("rd_valid_t1", 64'(mif.mem_rd_valid), 64'd0);
        while (done <= len && cyc < 2000) begin
            mif.mem_req_valid = 1'b0;
            mif.mem_wr_valid  = 1'b0;
            if (abort_left > 0 && (len + 1 - done) == abort_left) begin
                reset = 1'b1;
                mif.mem_rd_ready = 1'b0;
                tick;
                reset = 1'b0;
                check("abort_rd_valid", 64'(mif.mem_rd_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                return;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 2) : 1'($urandom_range(0, 1));
            mif.mem_rd_ready = rdy;
            if (inject && cyc == 3) begin
                check("err_before", 64'(err), 64'd0);
                mif.mem_req_valid  = 1'b1;
                mif.mem_req_opcode = 1'b1;
                mif.mem_req_len    = 8'd0;
                mif.mem_req_addr   = addr;
                mif.mem_wr_valid   = 1'b1;
                mif.mem_wr_bits    = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (inject && cyc == 4)
                check("err_rise", 64'(err), 64'd1);
            if (stalled) begin
                check("rd_hold_valid", 64'(mif.mem_rd_valid), 64'd1);
                check("rd_hold_bits", mif.mem_rd_bits, prev_bits);
            end
            if (mif.mem_rd_valid) begin
                if (first < 0) first = cyc;
                if (rdy) begin
                    if (known[(base + done) % DEPTH])
                        check("rd_data", mif.mem_rd_bits, model[(base + done) % DEPTH]);
                    done++;
                    last = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_bits = mif.mem_rd_bits;
                end
            end
            tick;
            cyc++;
        end
        mif.mem_rd_ready  = 1'b0;
        mif.mem_req_valid = 1'b0;
        mif.mem_wr_valid  = 1'b0;
        check("rd_beat_count", 64'(done), 64'(len + 1));
        if (lat_chk) begin
            check("rd_first_lat", 64'(first), 64'd2);
            check("rd_no_bubble", 64'(last - first), 64'(len));
        end
        check("rd_busy_fall", 64'(busy), 64'd0);
        check("rd_valid_after", 64'(mif.mem_rd_valid), 64'd0);
    endtask

    initial begin
        int w, len, span;
        logic [63:0] a;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        mif.mem_req_valid  = 1'b0;
        mif.mem_req_opcode = 1'b0;
        mif.mem_req_len    = '0;
        mif.mem_req_addr   = '0;
        mif.mem_wr_valid   = 1'b0;
        mif.mem_wr_bits    = '0;
        mif.mem_rd_ready   = 1'b0;

        pulse_reset;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_valid", 64'(mif.mem_rd_valid), 64'd0);
        check("rst_rd_bits", mif.mem_rd_bits, 64'd0);

        // Write then read back-to-back, with latency and throughput checks.
        wdata = '{64'h11, 64'h22, 64'h33, 64'h44};
        do_write(64'h40, 3, 0);
        do_read(64'h40, 3, 0, 1'b1, 1'b0, 0);

        // Eight-beat burst under 1,0,0 back-pressure.
        wdata = {};
        for (int i = 0; i < 8; i++) wdata.push_back({$urandom, $urandom});
        do_write(64'h100, 7, 0);
        do_read(64'h100, 7, 1, 1'b0, 1'b0, 0);

        // Single beat with a delayed write beat.
        wdata = '{64'hCAFE_F00D_0000_0008};
        do_write(64'h8, 0, 2);
        do_read(64'h8, 0, 0, 1'b1, 1'b0, 0);

        // Wrap at the RAM end: words 1023 and 0.
        wdata = '{64'hAAAA_0000_0000_03FF, 64'hBBBB_0000_0000_0000};
        do_write(64'h1FF8, 1, 0);
        do_read(64'h0, 0, 0, 1'b1, 1'b0, 0);
        do_read(64'h1FF8, 1, 2, 1'b0, 1'b0, 0);

        // Overlapping request during a read: dropped, burst intact, err sticky until reset.
        do_read(64'h100, 7, 0, 1'b1, 1'b1, 0);
        tick;
        check("err_sticky", 64'(err), 64'd1);
        pulse_reset;
        check("err_cleared", 64'(err), 64'd0);
        do_read(64'h40, 3, 2, 1'b0, 1'b0, 0);

        // Reset with three beats left, then re-read the same region.
        do_read(64'h100, 7, 0, 1'b0, 1'b0, 3);
        tick;
        do_read(64'h100, 7, 0, 1'b1, 1'b0, 0);

        // Randomized bursts over words 256..319 with aliasing address bits and offsets.
        wdata = {};
        for (int i = 0; i < 64; i++) wdata.push_back({$urandom, $urandom});
        do_write(64'h800, 63, 1);
        for (int it = 0; it < 40; it++) begin
            w    = int'($urandom_range(0, 63));
            span = 63 - w;
            len  = int'($urandom_range(0, (span < 15) ? span : 15));
            a    = (64'(256 + w) << 3) | 64'($urandom_range(0, 7)) | ({32'h0, $urandom} << 13);
            if ($urandom_range(0, 1) == 1) begin
                wdata = {};
                for (int i = 0; i <= len; i++) wdata.push_back({$urandom, $urandom});
                do_write(a, len, 1);
            end else begin
                do_read(a, len, int'($urandom_range(0, 2)), 1'b0, 1'b0, 0);
            end
            if ($urandom_range(0, 3) == 0) tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
